// File: rtl/pc_stack_unit.sv
// -----------------------------------------------------------------------------
// pc_stack_unit
//
// Program counter for the RNBIP processor family. It provides:
//   - increment and load of the PC
//   - a signed, PC-relative branch
//   - a hardware return-address stack with CALL and RET
//   - a sticky error flag for stack overflow and underflow
// PC_out drives the instruction-memory fetch address.
//
// Parameters
//   PC_W       width of the PC, of every target input and of each stack entry
//   STK_DEPTH  number of return-address entries (power of 2, >= 2)
//   RESET_VEC  PC value after reset; also the target selected by SEL = 2'b11
//   OFF_W      width of the signed relative-branch offset
//
// Ports
//   CLK, RST        clock and asynchronous active-high reset
//   I_PC            PC <= PC + 1
//   L_PC            PC <= target(SEL)
//   REL             PC <= PC + sign_extend(OFFSET)
//   CALL            push PC + 1, then PC <= target(SEL)
//   RET             pop the stack top into the PC
//   CLR_ERR         clear STK_ERR (a new error in the same cycle wins)
//   SEL             target select: 00 R0_in, 01 DM_in, 10 OR2_in, 11 RESET_VEC
//   R0_in, DM_in,
//   OR2_in          target sources
//   OFFSET          signed branch offset
//   PC_out          current PC (registered)
//   SP_out          number of stack entries in use, 0..STK_DEPTH
//   STK_FULL        SP_out == STK_DEPTH
//   STK_EMPTY       SP_out == 0
//   STK_ERR         sticky overflow/underflow flag
//
// When several commands are asserted together, only the highest-priority one
// acts. The order, highest first, is RET, CALL, L_PC, REL, I_PC.
// -----------------------------------------------------------------------------
module pc_stack_unit #(
    parameter int unsigned           PC_W      = 8,
    parameter int unsigned           STK_DEPTH = 4,
    parameter logic [PC_W-1:0]       RESET_VEC = '0,
    parameter int unsigned           OFF_W     = 8
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          I_PC,
    input  logic                          L_PC,
    input  logic                          REL,
    input  logic                          CALL,
    input  logic                          RET,
    input  logic                          CLR_ERR,
    input  logic [1:0]                    SEL,
    input  logic [PC_W-1:0]               R0_in,
    input  logic [PC_W-1:0]               DM_in,
    input  logic [PC_W-1:0]               OR2_in,
    input  logic [OFF_W-1:0]              OFFSET,
    output logic [PC_W-1:0]               PC_out,
    output logic [$clog2(STK_DEPTH):0]    SP_out,
    output logic                          STK_FULL,
    output logic                          STK_EMPTY,
    output logic                          STK_ERR
);

    localparam int unsigned IDX_W = $clog2(STK_DEPTH);
    localparam int unsigned SP_W  = IDX_W + 1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PC_W-1:0]  pc_q,  pc_d;
    logic [SP_W-1:0]  sp_q,  sp_d;
    logic             err_q, err_d;

    // The return-address storage has no reset. Its contents are only
    // meaningful below SP, and SP is cleared by reset.
    logic [PC_W-1:0]  stack_q [STK_DEPTH];

    logic             push_en;
    logic [PC_W-1:0]  target;
    logic [PC_W-1:0]  off_ext;
    logic [PC_W-1:0]  pc_plus1;
    logic [IDX_W-1:0] top_idx;
    logic [PC_W-1:0]  top_val;
    logic             full;
    logic             empty;

    // -------------------------------------------------------------------------
    // Offset extension to PC width. A wider offset is truncated. A narrower
    // offset is sign-extended, so that adding it wraps correctly in both
    // directions.
    // -------------------------------------------------------------------------
    generate
        if (OFF_W >= PC_W) begin : g_off_trunc
            assign off_ext = OFFSET[PC_W-1:0];
        end else begin : g_off_sext
            assign off_ext = {{(PC_W-OFF_W){OFFSET[OFF_W-1]}}, OFFSET};
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Target select. The case is fully specified, so SEL = 11 always yields
    // RESET_VEC and never an unknown value.
    // -------------------------------------------------------------------------
    always_comb begin
        target = RESET_VEC;
        case (SEL)
            2'b00:   target = R0_in;
            2'b01:   target = DM_in;
            2'b10:   target = OR2_in;
            default: target = RESET_VEC;
        endcase
    end

    assign pc_plus1 = pc_q + PC_W'(1);
    assign full     = (sp_q == SP_W'(STK_DEPTH));
    assign empty    = (sp_q == '0);

    // The top entry sits at SP-1. Only the low index bits are used. When
    // SP == STK_DEPTH these bits are zero, and subtracting one wraps to
    // STK_DEPTH-1, which is the correct slot.
    assign top_idx  = sp_q[IDX_W-1:0] - IDX_W'(1);
    assign top_val  = stack_q[top_idx];

    // -------------------------------------------------------------------------
    // Next-state logic, evaluated in command-priority order
    // -------------------------------------------------------------------------
    always_comb begin
        pc_d    = pc_q;
        sp_d    = sp_q;
        err_d   = err_q;
        push_en = 1'b0;

        // The clear is applied first. An error raised below in the same
        // cycle overrides it.
        if (CLR_ERR) begin
            err_d = 1'b0;
        end

        if (RET) begin
            if (empty) begin
                err_d = 1'b1;
            end else begin
                pc_d = top_val;
                sp_d = sp_q - SP_W'(1);
            end
        end else if (CALL) begin
            if (full) begin
                err_d = 1'b1;
            end else begin
                push_en = 1'b1;
                sp_d    = sp_q + SP_W'(1);
                pc_d    = target;
            end
        end else if (L_PC) begin
            pc_d = target;
        end else if (REL) begin
            pc_d = pc_q + off_ext;
        end else if (I_PC) begin
            pc_d = pc_plus1;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q  <= RESET_VEC;
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_en) begin
            stack_q[sp_q[IDX_W-1:0]] <= pc_plus1;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign PC_out    = pc_q;
    assign SP_out    = sp_q;
    assign STK_FULL  = full;
    assign STK_EMPTY = empty;
    assign STK_ERR   = err_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_stack_unit
//
// Directed testbench for pc_stack_unit with the default parameters:
// PC_W = 8, STK_DEPTH = 4, RESET_VEC = 0, OFF_W = 8.
// Every expected value below was computed by hand.
// -----------------------------------------------------------------------------
module tb_pc_stack_unit;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       I_PC = 1'b0, L_PC = 1'b0, REL = 1'b0, CALL = 1'b0, RET = 1'b0, CLR_ERR = 1'b0;
    logic [1:0] SEL = 2'b00;
    logic [7:0] R0_in = '0, DM_in = '0, OR2_in = '0, OFFSET = '0;
    logic [7:0] PC_out;
    logic [2:0] SP_out;
    logic       STK_FULL, STK_EMPTY, STK_ERR;

    int n_checks = 0;
    int n_pass   = 0;

    pc_stack_unit #(
        .PC_W      (8),
        .STK_DEPTH (4),
        .RESET_VEC (8'h00),
        .OFF_W     (8)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .I_PC      (I_PC),
        .L_PC      (L_PC),
        .REL       (REL),
        .CALL      (CALL),
        .RET       (RET),
        .CLR_ERR   (CLR_ERR),
        .SEL       (SEL),
        .R0_in     (R0_in),
        .DM_in     (DM_in),
        .OR2_in    (OR2_in),
        .OFFSET    (OFFSET),
        .PC_out    (PC_out),
        .SP_out    (SP_out),
        .STK_FULL  (STK_FULL),
        .STK_EMPTY (STK_EMPTY),
        .STK_ERR   (STK_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
            $display("ok   %s obs=%0h", tag, obs);
        end else begin
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Wait for one rising edge, then sample #1 after it. All commands are
    // dropped at that point, so each command is asserted for exactly one edge.
    task automatic step();
        @(posedge CLK);
        #1;
        I_PC = 1'b0; L_PC = 1'b0; REL = 1'b0; CALL = 1'b0; RET = 1'b0; CLR_ERR = 1'b0;
    endtask

    task automatic do_load(input logic [1:0] s, input logic [7:0] v);
        L_PC = 1'b1; SEL = s;
        case (s)
            2'b00:   R0_in  = v;
            2'b01:   DM_in  = v;
            default: OR2_in = v;
        endcase
        step();
    endtask

    task automatic do_call(input logic [7:0] r0v);
        CALL = 1'b1; SEL = 2'b00; R0_in = r0v;
        step();
    endtask

    task automatic do_ret();
        RET = 1'b1;
        step();
    endtask

    initial begin
        logic [7:0] exp8;
        logic [7:0] ret_exp [4];
        ret_exp[0] = 8'h51; ret_exp[1] = 8'h41; ret_exp[2] = 8'h31; ret_exp[3] = 8'h21;

        // ---------------- reset state ----------------
        @(posedge CLK); #1;
        check("rst_pc",    PC_out,    8'h00);
        check("rst_sp",    SP_out,    3'd0);
        check("rst_empty", STK_EMPTY, 1'b1);
        check("rst_full",  STK_FULL,  1'b0);
        check("rst_err",   STK_ERR,   1'b0);
        RST = 1'b0;

        // ---------------- increment with wrap ----------------
        for (int i = 1; i <= 256; i++) begin
            I_PC = 1'b1;
            step();
            exp8 = 8'(i);
            check($sformatf("inc_%0d", i), PC_out, exp8);
        end

        // No command asserted: the PC holds.
        step();
        check("hold_pc", PC_out, 8'h00);

        // ---------------- load and relative branch ----------------
        do_load(2'b01, 8'h40);
        check("load_dm", PC_out, 8'h40);
        REL = 1'b1; OFFSET = 8'hF0; step();
        check("rel_neg", PC_out, 8'h30);
        do_load(2'b10, 8'hF0);
        check("load_or2", PC_out, 8'hF0);
        REL = 1'b1; OFFSET = 8'h7F; step();
        check("rel_wrap", PC_out, 8'h6F);
        L_PC = 1'b1; SEL = 2'b11; step();
        check("load_vec", PC_out, 8'h00);

        // ---------------- nested calls ----------------
        do_load(2'b00, 8'h10);
        check("nest_start", PC_out, 8'h10);
        do_call(8'h80);
        check("call1_pc", PC_out, 8'h80);
        check("call1_sp", SP_out, 3'd1);
        CALL = 1'b1; SEL = 2'b10; OR2_in = 8'hA0; step();
        check("call2_pc", PC_out, 8'hA0);
        check("call2_sp", SP_out, 3'd2);
        do_ret();
        check("ret1_pc", PC_out, 8'h81);
        check("ret1_sp", SP_out, 3'd1);
        do_ret();
        check("ret2_pc",    PC_out,    8'h11);
        check("ret2_sp",    SP_out,    3'd0);
        check("ret2_empty", STK_EMPTY, 1'b1);

        // ---------------- overflow ----------------
        do_load(2'b00, 8'h20);
        do_call(8'h30);
        do_call(8'h40);
        do_call(8'h50);
        check("fill3_full", STK_FULL, 1'b0);
        do_call(8'h60);
        check("full_pc",    PC_out,   8'h60);
        check("full_sp",    SP_out,   3'd4);
        check("full_flag",  STK_FULL, 1'b1);
        check("full_err0",  STK_ERR,  1'b0);
        do_call(8'h70);
        check("ovf_pc",  PC_out,  8'h60);
        check("ovf_sp",  SP_out,  3'd4);
        check("ovf_err", STK_ERR, 1'b1);
        CLR_ERR = 1'b1; step();
        check("clr_err", STK_ERR, 1'b0);
        for (int i = 0; i < 4; i++) begin
            do_ret();
            check($sformatf("pop%0d_pc", i), PC_out, ret_exp[i]);
            check($sformatf("pop%0d_sp", i), SP_out, 32'(3 - i));
        end
        check("pop_empty", STK_EMPTY, 1'b1);

        // ---------------- underflow and error priority ----------------
        do_ret();
        check("udf_pc",  PC_out,  8'h21);
        check("udf_sp",  SP_out,  3'd0);
        check("udf_err", STK_ERR, 1'b1);
        CLR_ERR = 1'b1; step();
        check("udf_clr", STK_ERR, 1'b0);
        CLR_ERR = 1'b1; RET = 1'b1; step();
        check("clr_vs_err", STK_ERR, 1'b1);
        check("clr_vs_pc",  PC_out,  8'h21);

        // ---------------- command priority ----------------
        do_call(8'h90);
        check("pri_call_sp", SP_out, 3'd1);
        RET = 1'b1; CALL = 1'b1; I_PC = 1'b1; SEL = 2'b00; R0_in = 8'hEE; step();
        check("pri_ret_pc", PC_out, 8'h22);
        check("pri_ret_sp", SP_out, 3'd0);
        L_PC = 1'b1; I_PC = 1'b1; SEL = 2'b00; R0_in = 8'h55; step();
        check("pri_load", PC_out, 8'h55);
        REL = 1'b1; I_PC = 1'b1; OFFSET = 8'h02; step();
        check("pri_rel", PC_out, 8'h57);
        CALL = 1'b1; L_PC = 1'b1; SEL = 2'b00; R0_in = 8'h77; step();
        check("pri_call_pc", PC_out, 8'h77);
        check("pri_call_sp2", SP_out, 3'd1);

        // ---------------- asynchronous reset between edges ----------------
        #2;
        RST = 1'b1;
        #1;
        check("arst_pc",  PC_out,  8'h00);
        check("arst_sp",  SP_out,  3'd0);
        check("arst_err", STK_ERR, 1'b0);
        RST = 1'b0;
        I_PC = 1'b1; step();
        check("post_rst_inc", PC_out, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #100000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
